// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// MM:SS BCD countdown engine. The divided tick from the upstream clock
// divider is treated as a level that is edge-detected in the clk domain. It
// is never used as a clock. Each rising edge of tick_in is one time unit.
// Every entry into RUN fires a one-cycle div_start pulse. That restarts the
// divider phase, so the first decrement after a start or resume is always a
// full tick period away.
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high
//   tick_in     in   divider output (level), sampled on clk
//   load        in   capture load_min/load_sec (clamped per digit), go IDLE
//   load_min    in   [7:0] BCD minutes {tens, ones}
//   load_sec    in   [7:0] BCD seconds {tens, ones}
//   start_stop  in   single-cycle run/pause toggle
//   div_start   out  one-cycle pulse to the divider start input
//   min_bcd     out  [7:0] current minutes, BCD
//   sec_bcd     out  [7:0] current seconds, BCD
//   running     out  high while in RUN
//   expired     out  high while in EXPIRED
//   done        out  one-cycle pulse when the count reaches 00:00
// ---------------------------------------------------------------------------
module countdown_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start_stop,
  output logic       div_start,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic       r_tick_d;
  logic [3:0] r_min_t, r_min_o, r_sec_t, r_sec_o;
  logic       r_div_start, r_running, r_expired, r_done;

  logic       w_tick_edge;
  logic       w_count_zero;
  logic       w_do_dec;
  logic       w_dec_zero;
  logic [3:0] w_dec_min_t, w_dec_min_o, w_dec_sec_t, w_dec_sec_o;
  logic [3:0] w_ld_min_t, w_ld_min_o, w_ld_sec_t, w_ld_sec_o;
  logic       w_div_start_nxt, w_running_nxt, w_expired_nxt, w_done_nxt;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d,
                                             input logic [3:0] max_d);
    return (d > max_d) ? max_d : d;
  endfunction

  // Per-digit clamping of the load value. No binary conversion is involved.
  assign w_ld_min_t = clamp_digit(load_min[7:4], 4'd9);
  assign w_ld_min_o = clamp_digit(load_min[3:0], 4'd9);
  assign w_ld_sec_t = clamp_digit(load_sec[7:4], 4'd5);
  assign w_ld_sec_o = clamp_digit(load_sec[3:0], 4'd9);

  assign w_tick_edge  = tick_in & ~r_tick_d;
  assign w_count_zero = ({r_min_t, r_min_o, r_sec_t, r_sec_o} == 16'h0000);

  // A tick coinciding with start_stop or load is dropped. 00:00 is never
  // decremented, so the digits cannot wrap to 99:59.
  assign w_do_dec = (r_state == S_RUN) & w_tick_edge & ~start_stop & ~load
                  & ~w_count_zero;

  // BCD borrow chain, one 4-bit digit at a time.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    w_dec_min_t = r_min_t;
    w_dec_min_o = r_min_o;
    w_dec_sec_t = r_sec_t;
    w_dec_sec_o = r_sec_o;
    if (r_sec_o != 4'd0) begin
      w_dec_sec_o = r_sec_o - 4'd1;
    end else begin
      w_dec_sec_o = 4'd9;
      if (r_sec_t != 4'd0) begin
        w_dec_sec_t = r_sec_t - 4'd1;
      end else begin
        w_dec_sec_t = 4'd5;
        if (r_min_o != 4'd0) begin
          w_dec_min_o = r_min_o - 4'd1;
        end else begin
          w_dec_min_o = 4'd9;
          w_dec_min_t = r_min_t - 4'd1;
        end
      end
    end
  end

  assign w_dec_zero = ({w_dec_min_t, w_dec_min_o, w_dec_sec_t, w_dec_sec_o}
                       == 16'h0000);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic. load outranks start_stop and tick_edge in every state.
  always_comb begin
    w_next_state = r_state;
    if (load) begin
      w_next_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:    if (start_stop && !w_count_zero) w_next_state = S_RUN;
        S_RUN: begin
          if (start_stop)                  w_next_state = S_PAUSE;
          else if (w_do_dec && w_dec_zero) w_next_state = S_EXPIRED;
        end
        S_PAUSE:   if (start_stop) w_next_state = S_RUN;
        S_EXPIRED: w_next_state = S_EXPIRED;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  // Output logic. Each output is computed from the transition being taken
  // and is registered below, so every output changes on the same edge as
  // the state.
  always_comb begin
    w_running_nxt   = (w_next_state == S_RUN);
    w_expired_nxt   = (w_next_state == S_EXPIRED);
    w_div_start_nxt = (w_next_state == S_RUN) && (r_state != S_RUN);
    w_done_nxt      = (r_state == S_RUN) && (w_next_state == S_EXPIRED);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is only tested inside the clocked
    // branch. It overrides load, decrement and a div_start pulse alike.
    if (reset) begin
      r_tick_d    <= 1'b0;
      r_min_t     <= 4'd0;
      r_min_o     <= 4'd0;
      r_sec_t     <= 4'd0;
      r_sec_o     <= 4'd0;
      r_div_start <= 1'b0;
      r_running   <= 1'b0;
      r_expired   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_tick_d    <= tick_in;
      r_div_start <= w_div_start_nxt;
      r_running   <= w_running_nxt;
      r_expired   <= w_expired_nxt;
      r_done      <= w_done_nxt;
      if (load) begin
        r_min_t <= w_ld_min_t;
        r_min_o <= w_ld_min_o;
        r_sec_t <= w_ld_sec_t;
        r_sec_o <= w_ld_sec_o;
      end else if (w_do_dec) begin
        r_min_t <= w_dec_min_t;
        r_min_o <= w_dec_min_o;
        r_sec_t <= w_dec_sec_t;
        r_sec_o <= w_dec_sec_o;
      end
    end
  end

  assign div_start = r_div_start;
  assign min_bcd   = {r_min_t, r_min_o};
  assign sec_bcd   = {r_sec_t, r_sec_o};
  assign running   = r_running;
  assign expired   = r_expired;
  assign done      = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//
// Drives countdown_timer from directed scenarios and a randomized stream.
// A reference model holds the count as a plain number of seconds and the
// mode as a small integer. It runs alongside the DUT and is compared with
// it. An EVEN_DIV=4 divider model supplies tick_in for the timing scenarios.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int HALF = 2;  // EVEN_DIV / 2

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_in;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start_stop;
  logic       div_start;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       expired;
  logic       done;

  logic tick_man;
  logic use_div;
  logic div_run;
  logic div_q   = 1'b0;
  int   div_cnt = 0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign tick_in = use_div ? div_q : tick_man;

  countdown_timer dut (
    .clk        (clk),
    .reset      (reset),
    .tick_in    (tick_in),
    .load       (load),
    .load_min   (load_min),
    .load_sec   (load_sec),
    .start_stop (start_stop),
    .div_start  (div_start),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd),
    .running    (running),
    .expired    (expired),
    .done       (done)
  );

  // Upstream divider: holds low while disabled. A start sampled at an edge
  // clears its phase, and the output then toggles every HALF cycles.
  always @(posedge clk) begin
    if (!div_run || div_start) begin
      div_q   <= 1'b0;
      div_cnt <= 0;
    end else if (div_cnt == HALF - 1) begin
      div_q   <= ~div_q;
      div_cnt <= 0;
    end else begin
      div_cnt <= div_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  int m_mode   = M_IDLE;
  int m_total  = 0;     // remaining time in seconds
  bit m_tick_d = 1'b0;
  bit m_done   = 1'b0;
  bit m_div    = 1'b0;
  bit m_rise;

  function automatic int clamped_secs(input logic [7:0] mn, input logic [7:0] sc);
    int mt, mo, st, so;
    mt = int'(mn[7:4]); mo = int'(mn[3:0]);
    st = int'(sc[7:4]); so = int'(sc[3:0]);
    if (mt > 9) mt = 9;
    if (mo > 9) mo = 9;
    if (st > 5) st = 5;
    if (so > 9) so = 9;
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic logic [19:0] model_vec();
    return {to_bcd(m_total / 60), to_bcd(m_total % 60),
            m_mode == M_RUN, m_mode == M_EXP, m_done, m_div};
  endfunction

  always @(posedge clk) begin
    m_rise = tick_in && !m_tick_d;
    if (reset) begin
      m_mode   <= M_IDLE;
      m_total  <= 0;
      m_tick_d <= 1'b0;
      m_done   <= 1'b0;
      m_div    <= 1'b0;
    end else begin
      m_tick_d <= tick_in;
      m_done   <= 1'b0;
      m_div    <= 1'b0;
      if (load) begin
        m_mode  <= M_IDLE;
        m_total <= clamped_secs(load_min, load_sec);
      end else if (start_stop) begin
        if ((m_mode == M_IDLE && m_total != 0) || m_mode == M_PAUSE) begin
          m_mode <= M_RUN;
          m_div  <= 1'b1;
        end else if (m_mode == M_RUN) begin
          m_mode <= M_PAUSE;
        end
      end else if (m_mode == M_RUN && m_rise && m_total > 0) begin
        m_total <= m_total - 1;
        if (m_total == 1) begin
          m_mode <= M_EXP;
          m_done <= 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_load(input logic [7:0] mn, input logic [7:0] sc);
    load = 1'b1; load_min = mn; load_sec = sc;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  task automatic tick_pulse();
    tick_man = 1'b1;
    @(negedge clk);
    tick_man = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [19:0] obs;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick_man = ~tick_man;
      @(negedge clk);
    end
    obs = {min_bcd, sec_bcd, running, expired, done, div_start};
    n_checks++;
    if (obs !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 20'h0);
    end
    reset = 1'b0; tick_man = 1'b0;
    @(negedge clk);
    pulse_ss();
    n_checks++;
    if ({running, div_start} !== 2'b00) begin
      n_fail++;
      $display("FAIL ss_at_zero: running/div_start got %b expected 00", {running, div_start});
    end
    @(negedge clk);
    n_checks++;
    if ({running, div_start, expired} !== 3'b000) begin
      n_fail++;
      $display("FAIL ss_at_zero_hold: got %b expected 000", {running, div_start, expired});
    end
  endtask

  task automatic test_countdown3();
    logic [7:0]  e_sec;
    logic [11:0] obs, exp_v;
    use_div = 1'b1; div_run = 1'b0;
    pulse_load(8'h00, 8'h03);
    n_checks++;
    if ({min_bcd, sec_bcd, running} !== {8'h00, 8'h03, 1'b0}) begin
      n_fail++;
      $display("FAIL load_0003: got %h:%h run=%b expected 00:03 run=0", min_bcd, sec_bcd, running);
    end
    start_stop = 1'b1; div_run = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    n_checks++;
    if ({div_start, running} !== 2'b11) begin
      n_fail++;
      $display("FAIL start_pulse: div_start/running got %b expected 11", {div_start, running});
    end
    for (int off = 1; off <= 20; off++) begin
      @(negedge clk);
      e_sec = (off < 4) ? 8'h03 : (off < 8) ? 8'h02 : (off < 12) ? 8'h01 : 8'h00;
      obs   = {sec_bcd, done, expired, running, div_start};
      exp_v = {e_sec, off == 12, off >= 12, off < 12, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL countdown3 off=%0d: got %h expected %h", off, obs, exp_v);
      end
      n_checks++;
      if ({min_bcd, sec_bcd, running, expired, done, div_start} !== model_vec()) begin
        n_fail++;
        $display("FAIL countdown3_model off=%0d: got %h expected %h", off,
                 {min_bcd, sec_bcd, running, expired, done, div_start}, model_vec());
      end
    end
    div_run = 1'b0; use_div = 1'b0; tick_man = 1'b0;
  endtask

  task automatic test_borrow();
    logic [7:0] mins[2];
    logic [15:0] want[2];
    mins[0] = 8'h10; want[0] = 16'h0959;
    mins[1] = 8'h01; want[1] = 16'h0059;
    tick_man = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pulse_load(mins[i], 8'h00);
      pulse_ss();
      tick_pulse();
      n_checks++;
      if ({min_bcd, sec_bcd} !== want[i]) begin
        n_fail++;
        $display("FAIL borrow_%0d: got %h expected %h", i, {min_bcd, sec_bcd}, want[i]);
      end
    end
  endtask

  task automatic test_clamp();
    logic [15:0] in_v[3];
    logic [15:0] want[3];
    in_v[0] = 16'hA77C; want[0] = 16'h9759;
    in_v[1] = 16'h5A6F; want[1] = 16'h5959;
    in_v[2] = 16'h9959; want[2] = 16'h9959;
    for (int i = 0; i < 3; i++) begin
      pulse_load(in_v[i][15:8], in_v[i][7:0]);
      n_checks++;
      if ({min_bcd, sec_bcd, running, expired} !== {want[i], 2'b00}) begin
        n_fail++;
        $display("FAIL clamp_%0d: got %h run=%b exp=%b expected %h idle", i,
                 {min_bcd, sec_bcd}, running, expired, want[i]);
      end
    end
  endtask

  task automatic test_pause();
    use_div = 1'b0; div_run = 1'b0; tick_man = 1'b0;
    pulse_load(8'h00, 8'h05);
    pulse_ss();
    tick_pulse();
    n_checks++;
    if ({sec_bcd, running} !== {8'h04, 1'b1}) begin
      n_fail++;
      $display("FAIL pause_first_tick: got %h run=%b expected 04 run=1", sec_bcd, running);
    end
    start_stop = 1'b1; tick_man = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    n_checks++;
    if ({sec_bcd, running} !== {8'h04, 1'b0}) begin
      n_fail++;
      $display("FAIL pause_tick_dropped: got %h run=%b expected 04 run=0", sec_bcd, running);
    end
    for (int i = 0; i < 10; i++) begin
      tick_man = 1'b0; @(negedge clk);
      tick_man = 1'b1; @(negedge clk);
    end
    tick_man = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({sec_bcd, running, div_start} !== {8'h04, 2'b00}) begin
      n_fail++;
      $display("FAIL pause_hold: got %h run=%b ds=%b expected 04 0 0", sec_bcd, running, div_start);
    end
    use_div = 1'b1; start_stop = 1'b1; div_run = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    n_checks++;
    if ({div_start, running} !== 2'b11) begin
      n_fail++;
      $display("FAIL resume_pulse: got %b expected 11", {div_start, running});
    end
    for (int off = 1; off <= 4; off++) begin
      @(negedge clk);
      n_checks++;
      if (sec_bcd !== ((off < 4) ? 8'h04 : 8'h03)) begin
        n_fail++;
        $display("FAIL resume_period off=%0d: got %h expected %h", off, sec_bcd,
                 (off < 4) ? 8'h04 : 8'h03);
      end
    end
    div_run = 1'b0; use_div = 1'b0; tick_man = 1'b0;
  endtask

  task automatic test_simultaneous();
    tick_man = 1'b0;
    pulse_load(8'h00, 8'h05);
    pulse_ss();
    tick_pulse();
    load = 1'b1; load_min = 8'h00; load_sec = 8'h02; start_stop = 1'b1;
    @(negedge clk);
    load = 1'b0; start_stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({min_bcd, sec_bcd, running, expired, done, div_start} !== {16'h0002, 4'b0000}) begin
        n_fail++;
        $display("FAIL load_over_ss_%0d: got %h expected %h", i,
                 {min_bcd, sec_bcd, running, expired, done, div_start}, {16'h0002, 4'b0000});
      end
      @(negedge clk);
    end
    pulse_ss();
    tick_pulse();
    @(negedge clk);
    tick_man = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({sec_bcd, done, expired, running} !== {8'h00, 3'b110}) begin
      n_fail++;
      $display("FAIL final_dec: got %h d/e/r=%b expected 00 110", sec_bcd, {done, expired, running});
    end
    tick_man = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({done, expired} !== 2'b01) begin
      n_fail++;
      $display("FAIL done_one_cycle: done/expired got %b expected 01", {done, expired});
    end
    pulse_ss();
    n_checks++;
    if ({expired, running, div_start, sec_bcd} !== {3'b100, 8'h00}) begin
      n_fail++;
      $display("FAIL expired_ignores_ss: got %b/%h expected 100/00",
               {expired, running, div_start}, sec_bcd);
    end
    pulse_load(8'h00, 8'h07);
    n_checks++;
    if ({expired, sec_bcd} !== {1'b0, 8'h07}) begin
      n_fail++;
      $display("FAIL load_clears_expired: got %b/%h expected 0/07", expired, sec_bcd);
    end
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({min_bcd, sec_bcd, running, expired, done, div_start} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_mid_pulse: got %h expected 0",
               {min_bcd, sec_bcd, running, expired, done, div_start});
    end
  endtask

  task automatic test_random();
    use_div = 1'b0; div_run = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset      = ($urandom_range(0, 299) == 0);
      load       = ($urandom_range(0, 39) == 0);
      load_min   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      load_sec   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom);
      start_stop = ($urandom_range(0, 7) == 0);
      tick_man   = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if ({min_bcd, sec_bcd, running, expired, done, div_start} !== model_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d: got %h expected %h", cyc,
                 {min_bcd, sec_bcd, running, expired, done, div_start}, model_vec());
      end
    end
    reset = 1'b0; load = 1'b0; start_stop = 1'b0; tick_man = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_min = 8'h00; load_sec = 8'h00;
    start_stop = 1'b0; tick_man = 1'b0; use_div = 1'b0; div_run = 1'b0;
    @(negedge clk);
    test_reset();
    test_countdown3();
    test_borrow();
    test_clamp();
    test_pause();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
